// File: rtl/conv_k_mem_reader.sv
// conv_k_mem_reader: read-address sequencer for a multi-port kernel weight ROM.
// The NKERN kernels are split into NPORT contiguous windows of SPAN weights each.
// One shared offset counter drives every port at once, one weight per port per cycle.
// A tag pipeline delays the issue strobe by the memory latency, so that valid/widx/kidx
// line up with the returned data.
module conv_k_mem_reader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned BASE   = 0,
   parameter int unsigned KSIZE  = 25,
   parameter int unsigned NKERN  = 6,
   parameter int unsigned NPORT  = 2,
   parameter int unsigned RD_LAT = 1,
   localparam int unsigned KPP    = NKERN / NPORT,
   localparam int unsigned SPAN   = KPP * KSIZE,
   localparam int unsigned OFF_W  = (SPAN > 1) ? $clog2(SPAN) : 1,
   localparam int unsigned WIDX_W = (KSIZE > 1) ? $clog2(KSIZE) : 1,
   localparam int unsigned KIDX_W = (KPP > 1) ? $clog2(KPP) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    stall,
   input  logic                    abort,
   output logic [NPORT*ADDR_W-1:0] addr,
   output logic                    rd_en,
   output logic                    valid,
   output logic [WIDX_W-1:0]       widx,
   output logic [KIDX_W-1:0]       kidx,
   output logic                    busy,
   output logic                    done
);

   // Parameter sanity, caught at elaboration.
   if ((NKERN % NPORT) != 0) begin : g_err_nport
      $error("conv_k_mem_reader: NKERN must be a multiple of NPORT");
   end
   if ((64'(BASE) + 64'(NKERN) * 64'(KSIZE)) > (64'd1 << ADDR_W)) begin : g_err_addr
      $error("conv_k_mem_reader: last weight address does not fit ADDR_W");
   end
   if (RD_LAT > 7) begin : g_err_lat
      $error("conv_k_mem_reader: RD_LAT must be 0..7");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam logic [OFF_W-1:0]  OffLast   = OFF_W'(SPAN - 1);
   localparam logic [WIDX_W-1:0] WidxLast  = WIDX_W'(KSIZE - 1);
   // Only meaningful when RD_LAT > 0; DRAIN is never entered otherwise.
   localparam logic [2:0]        DrainLast = 3'(RD_LAT - 1);

   state_e              state_q, state_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [WIDX_W-1:0]   w_q, w_d;
   logic [KIDX_W-1:0]   k_q, k_d;
   logic [2:0]          drain_q, drain_d;

   // State, offset and tag wrap counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         off_q   <= '0;
         w_q     <= '0;
         k_q     <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         w_q     <= w_d;
         k_q     <= k_d;
         drain_q <= drain_d;
      end
   end

   // Next-state, counter advance and read strobe; abort overrides everything.
   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      w_d     = w_q;
      k_d     = k_q;
      drain_d = drain_q;
      rd_en   = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StRun;
               off_d   = '0;
               w_d     = '0;
               k_d     = '0;
            end
         end
         StRun: begin
            rd_en = !stall;
            if (!stall) begin
               if (off_q == OffLast) begin
                  // Offset holds on the final issue; the tags keep the last weight.
                  drain_d = '0;
                  if (RD_LAT == 0) begin
                     state_d = StDone;
                  end else begin
                     state_d = StDrain;
                  end
               end else begin
                  off_d = off_q + OFF_W'(1);
                  if (w_q == WidxLast) begin
                     w_d = '0;
                     k_d = k_q + KIDX_W'(1);
                  end else begin
                     w_d = w_q + WIDX_W'(1);
                  end
               end
            end
         end
         StDrain: begin
            if (drain_q == DrainLast) begin
               state_d = StDone;
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (abort) begin
         state_d = StIdle;
         off_d   = '0;
         w_d     = '0;
         k_d     = '0;
         drain_d = '0;
      end
   end

   assign busy = (state_q == StRun) || (state_q == StDrain);
   assign done = (state_q == StDone);

   // Each port reads its own window at the shared offset.
   for (genvar p = 0; p < NPORT; p++) begin : g_port
      localparam int unsigned PortBase = BASE + p * SPAN;
      assign addr[p*ADDR_W +: ADDR_W] = PortBase[ADDR_W-1:0] + ADDR_W'(off_q);
   end

   if (RD_LAT == 0) begin : g_lat0
      assign valid = rd_en;
      assign widx  = w_q;
      assign kidx  = k_q;
   end else begin : g_pipe
      logic [RD_LAT-1:0] vld_q;
      logic [WIDX_W-1:0] widx_q [RD_LAT];
      logic [KIDX_W-1:0] kidx_q [RD_LAT];

      // Latency-matching shift of {rd_en, widx, kidx}; runs through stalls, flushed by abort.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
               widx_q[i] <= '0;
               kidx_q[i] <= '0;
            end
         end else if (abort) begin
            vld_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
               widx_q[i] <= '0;
               kidx_q[i] <= '0;
            end
         end else begin
            vld_q[0]  <= rd_en;
            widx_q[0] <= w_q;
            kidx_q[0] <= k_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
               vld_q[i]  <= vld_q[i-1];
               widx_q[i] <= widx_q[i-1];
               kidx_q[i] <= kidx_q[i-1];
            end
         end
      end

      assign valid = vld_q[RD_LAT-1];
      assign widx  = widx_q[RD_LAT-1];
      assign kidx  = kidx_q[RD_LAT-1];
   end

endmodule

// File: tb/tb_conv_k_mem_reader.sv
// tb_conv_k_mem_reader: scoreboard bench for the default 2-port instance and a
// 3-port, 2-cycle-latency instance.
module tb_conv_k_mem_reader;

   localparam int SPAN_A  = 75;
   localparam int KSIZE_A = 25;
   localparam int SPAN_B  = 18;
   localparam int KSIZE_B = 9;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_a, stall_a, abort_a;
   logic [15:0] addr_a;
   logic        rd_en_a, valid_a, busy_a, done_a;
   logic [4:0]  widx_a;
   logic [1:0]  kidx_a;
   logic        start_b, stall_b, abort_b;
   logic [23:0] addr_b;
   logic        rd_en_b, valid_b, busy_b, done_b;
   logic [3:0]  widx_b;
   logic [0:0]  kidx_b;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   conv_k_mem_reader u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .stall(stall_a), .abort(abort_a),
      .addr(addr_a), .rd_en(rd_en_a), .valid(valid_a), .widx(widx_a), .kidx(kidx_a),
      .busy(busy_a), .done(done_a)
   );

   conv_k_mem_reader #(
      .ADDR_W(8), .BASE(16), .KSIZE(9), .NKERN(6), .NPORT(3), .RD_LAT(2)
   ) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .stall(stall_b), .abort(abort_b),
      .addr(addr_b), .rd_en(rd_en_b), .valid(valid_b), .widx(widx_b), .kidx(kidx_b),
      .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      reset = 1'b1;
      start_a = 0; stall_a = 0; abort_a = 0;
      start_b = 0; stall_b = 0; abort_b = 0;
      @(negedge clk);
      checks++;
      if ({rd_en_a, valid_a, busy_a, done_a, widx_a, kidx_a} !== 11'd0) begin
         errors++;
         $display("FAIL reset_a_ctl: got rd=%b v=%b b=%b d=%b w=%0d k=%0d want all 0",
                  rd_en_a, valid_a, busy_a, done_a, widx_a, kidx_a);
      end
      checks++;
      if (addr_a !== {8'd75, 8'd0}) begin
         errors++; $display("FAIL reset_a_addr: got %h want 4b00", addr_a);
      end
      checks++;
      if (addr_b !== {8'd52, 8'd34, 8'd16}) begin
         errors++; $display("FAIL reset_b_addr: got %h want 342210", addr_b);
      end
      checks++;
      if ({rd_en_b, valid_b, busy_b, done_b} !== 4'd0) begin
         errors++; $display("FAIL reset_b_ctl: got %b want 0000",
                            {rd_en_b, valid_b, busy_b, done_b});
      end
      reset = 1'b0;
   endtask

   // Full sweep on instance A; stall is raised on cycles st_lo..st_hi after the start edge.
   task automatic test_sweep(input string name, input int st_lo, input int st_hi);
      int moff, issued, beats, last_c, t;
      logic exp_rd, prev_rd, exp_done;
      exp_q.delete();
      @(posedge clk); #1; start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      moff = 0; issued = 0; beats = 0; last_c = 100000; prev_rd = 1'b0;
      for (int c = 1; c < 400; c++) begin
         stall_a = (c >= st_lo && c <= st_hi);
         @(negedge clk);
         exp_rd   = (issued < SPAN_A) && !stall_a;
         exp_done = (c >= last_c + 2);
         checks++;
         if (rd_en_a !== exp_rd) begin
            errors++; $display("FAIL %s rd_en c=%0d: got %b want %b", name, c, rd_en_a, exp_rd);
         end
         checks++;
         if (addr_a !== {8'(SPAN_A + moff), 8'(moff)}) begin
            errors++; $display("FAIL %s addr c=%0d: got %h want off %0d", name, c, addr_a, moff);
         end
         checks++;
         if (valid_a !== prev_rd) begin
            errors++; $display("FAIL %s valid c=%0d: got %b want %b", name, c, valid_a, prev_rd);
         end
         checks++;
         if (done_a !== exp_done || busy_a !== !exp_done) begin
            errors++; $display("FAIL %s done/busy c=%0d: got %b/%b want %b/%b", name, c,
                               done_a, busy_a, exp_done, !exp_done);
         end
         if (valid_a === 1'b1) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL %s extra_beat c=%0d: got valid want none", name, c);
            end else begin
               t = exp_q.pop_front();
               if (widx_a !== 5'(t / 256) || kidx_a !== 2'(t % 256)) begin
                  errors++; $display("FAIL %s tag c=%0d: got w=%0d k=%0d want w=%0d k=%0d",
                                     name, c, widx_a, kidx_a, t / 256, t % 256);
               end
            end
         end
         if (exp_rd) begin
            exp_q.push_back((moff % KSIZE_A) * 256 + moff / KSIZE_A);
            issued++;
            if (issued == SPAN_A) last_c = c;
            else moff++;
         end
         prev_rd = exp_rd;
         if (exp_done) break;
         @(posedge clk); #1;
      end
      stall_a = 1'b0;
      checks++;
      if (beats != SPAN_A) begin
         errors++; $display("FAIL %s beats: got %0d want %0d", name, beats, SPAN_A);
      end
   endtask

   task automatic test_abort();
      @(posedge clk); #1; start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      for (int c = 1; c <= 41; c++) begin
         abort_a = (c == 41);
         @(negedge clk);
         if (c == 41) begin
            checks++;
            if (rd_en_a !== 1'b1 || addr_a !== {8'd115, 8'd40}) begin
               errors++; $display("FAIL abort_pre: got rd=%b addr=%h want 1/7328", rd_en_a, addr_a);
            end
         end
         @(posedge clk); #1;
      end
      abort_a = 1'b0;
      @(negedge clk);
      checks++;
      if (addr_a !== {8'd75, 8'd0}) begin
         errors++; $display("FAIL abort_addr: got %h want 4b00", addr_a);
      end
      checks++;
      if ({busy_a, done_a, rd_en_a, valid_a} !== 4'd0) begin
         errors++; $display("FAIL abort_ctl: got b/d/rd/v=%b want 0000",
                            {busy_a, done_a, rd_en_a, valid_a});
      end
   endtask

   // start held high: first sweep ends, DONE lasts one cycle, second sweep follows.
   task automatic test_back_to_back();
      int exp_a0;
      logic exp_rd, exp_done;
      @(posedge clk); #1; start_a = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         exp_rd   = (c <= SPAN_A) || (c >= 78);
         exp_done = (c == 77);
         exp_a0   = (c <= SPAN_A) ? c - 1 : (c < 78) ? SPAN_A - 1 : c - 78;
         checks++;
         if (rd_en_a !== exp_rd || done_a !== exp_done || addr_a[7:0] !== 8'(exp_a0)) begin
            errors++; $display("FAIL b2b c=%0d: got rd=%b d=%b a0=%0d want %b %b %0d", c,
                               rd_en_a, done_a, addr_a[7:0], exp_rd, exp_done, exp_a0);
         end
         @(posedge clk); #1;
      end
      start_a = 1'b0; abort_a = 1'b1;
      @(posedge clk); #1; abort_a = 1'b0;
   endtask

   task automatic test_nport3();
      int moff, issued, beats, last_c, t;
      logic exp_rd, exp_done;
      logic [1:0] hist;
      exp_q.delete();
      @(posedge clk); #1; start_b = 1'b1;
      @(posedge clk); #1; start_b = 1'b0;
      moff = 0; issued = 0; beats = 0; last_c = 100000; hist = 2'b00;
      for (int c = 1; c < 100; c++) begin
         @(negedge clk);
         exp_rd   = (issued < SPAN_B);
         exp_done = (c >= last_c + 3);
         checks++;
         if (rd_en_b !== exp_rd || valid_b !== hist[1] || done_b !== exp_done) begin
            errors++; $display("FAIL np3_ctl c=%0d: got rd=%b v=%b d=%b want %b %b %b", c,
                               rd_en_b, valid_b, done_b, exp_rd, hist[1], exp_done);
         end
         checks++;
         if (addr_b !== {8'(52 + moff), 8'(34 + moff), 8'(16 + moff)}) begin
            errors++; $display("FAIL np3_addr c=%0d: got %h want off %0d", c, addr_b, moff);
         end
         if (valid_b === 1'b1) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL np3_extra c=%0d: got valid want none", c);
            end else begin
               t = exp_q.pop_front();
               if (widx_b !== 4'(t / 256) || kidx_b !== 1'(t % 256)) begin
                  errors++; $display("FAIL np3_tag c=%0d: got w=%0d k=%0d want w=%0d k=%0d",
                                     c, widx_b, kidx_b, t / 256, t % 256);
               end
            end
         end
         if (exp_rd) begin
            exp_q.push_back((moff % KSIZE_B) * 256 + moff / KSIZE_B);
            issued++;
            if (issued == SPAN_B) last_c = c;
            else moff++;
         end
         hist = {hist[0], exp_rd};
         if (exp_done) break;
         @(posedge clk); #1;
      end
      checks++;
      if (beats != SPAN_B) begin
         errors++; $display("FAIL np3_beats: got %0d want %0d", beats, SPAN_B);
      end
   endtask

   // Reset raised between edges while instance B drains.
   task automatic test_async_reset();
      @(posedge clk); #1; start_b = 1'b1;
      @(posedge clk); #1; start_b = 1'b0;
      for (int c = 1; c < 19; c++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if ({busy_b, rd_en_b, valid_b, done_b} !== 4'b1010) begin
         errors++; $display("FAIL drain_pre: got b/rd/v/d=%b want 1010",
                            {busy_b, rd_en_b, valid_b, done_b});
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({busy_b, rd_en_b, valid_b, done_b, widx_b, kidx_b} !== 9'd0 ||
          addr_b !== {8'd52, 8'd34, 8'd16}) begin
         errors++; $display("FAIL async_reset: got b/rd/v/d=%b w=%0d k=%0d addr=%h want 0 342210",
                            {busy_b, rd_en_b, valid_b, done_b}, widx_b, kidx_b, addr_b);
      end
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy_b, valid_b, done_b} !== 3'd0) begin
         errors++; $display("FAIL post_reset: got b/v/d=%b want 000", {busy_b, valid_b, done_b});
      end
   endtask

   initial begin
      test_reset();
      test_sweep("sweep", 0, -1);
      test_sweep("stall", 11, 13);
      test_abort();
      test_sweep("restart", 0, -1);
      test_back_to_back();
      test_nport3();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
